eth_reg_arbiter: RTL and testbench

// Round-robin arbiter and sequencer for the KSZ8851 register-bus engine (RegIO).

---
 rtl/eth_reg_arbiter.sv | 178 +++++++++++++++++
 tb/tb_eth_reg_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_reg_arbiter.sv
// eth_reg_arbiter: round-robin arbiter and sequencer for the KSZ8851 register-bus
// engine. Grants one requester at a time, drives the engine command, follows the
// engine state back to Wait, returns read data with a one-hot done pulse and
// aborts with an error pulse if the engine hangs.
module eth_reg_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk40m,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ-1:0]    req_length,
  input  logic [NUM_REQ*8-1:0]  req_offset,
  input  logic [NUM_REQ*16-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  eng_wr,
  output logic                  eng_length,
  output logic [7:0]            eng_offset,
  output logic [15:0]           eng_wdata,
  output logic                  eng_new,
  input  logic [3:0]            eng_state,
  input  logic [15:0]           eng_rdata
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0]      ENG_WAIT = 4'h9;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win;
  logic [WD_W-1:0]  wdog;

  logic [PTR_W-1:0] pick;
  logic             can_grant;
  logic             timeout;
  logic             pick_wr;
  logic             pick_len;
  logic [7:0]       pick_off;
  logic [15:0]      pick_wdata;

  // Next index after p, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) >= NUM_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // First valid requester at or after p, searching cyclically.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [PTR_W-1:0]   p);
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] sel;
    logic             found;
    idx   = p;
    sel   = p;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && v[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = ptr_inc(idx);
    end
    return sel;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] w);
    logic [NUM_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w == PTR_W'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // A done pulse still on the bus means the requester has not yet seen it;
  // holding off one cycle keeps its old request from being granted twice.
  assign pick      = rr_pick(req_valid, rr_ptr);
  assign can_grant = (|req_valid) && (eng_state == ENG_WAIT) && !(|req_done);
  assign timeout   = ((state == ISSUE) || (state == BUSY)) && (wdog == WD_LAST);

  // Select the command fields of the requester about to be granted.
  always_comb begin
    pick_wr    = 1'b0;
    pick_len   = 1'b0;
    pick_off   = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == PTR_W'(i)) begin
        pick_wr    = req_wr[i];
        pick_len   = req_length[i];
        pick_off   = req_offset[8*i +: 8];
        pick_wdata = req_wdata[16*i +: 16];
      end
    end
  end

  // Sequencer: grant, issue, track the engine, complete or time out.
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win        <= '0;
      wdog       <= '0;
      req_grant  <= '0;
      req_done   <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      eng_wr     <= 1'b0;
      eng_length <= 1'b0;
      eng_offset <= '0;
      eng_wdata  <= '0;
      eng_new    <= 1'b0;
    end else begin
      req_grant <= '0;
      req_done  <= '0;
      rsp_err   <= 1'b0;
      if (timeout) begin
        eng_new  <= 1'b0;
        req_done <= onehot(win);
        rsp_err  <= 1'b1;
        rr_ptr   <= ptr_inc(win);
        busy     <= 1'b0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (can_grant) begin
              win        <= pick;
              eng_wr     <= pick_wr;
              eng_length <= pick_len;
              eng_offset <= pick_off;
              eng_wdata  <= pick_wdata;
              req_grant  <= onehot(pick);
              eng_new    <= 1'b1;
              wdog       <= '0;
              busy       <= 1'b1;
              state      <= ISSUE;
            end
          end
          ISSUE: begin
            wdog <= wdog + 1'b1;
            if (eng_state != ENG_WAIT) begin
              eng_new <= 1'b0;
              state   <= BUSY;
            end
          end
          BUSY: begin
            wdog <= wdog + 1'b1;
            if (eng_state == ENG_WAIT) state <= DONE;
          end
          DONE: begin
            if (!eng_wr) rsp_rdata <= eng_rdata;
            req_done <= onehot(win);
            rr_ptr   <= ptr_inc(win);
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_reg_arbiter.sv
// tb_eth_reg_arbiter: self-checking bench for eth_reg_arbiter with a small
// behavioural RegIO engine (Wait -> Addr0..5 -> Wait) and a round-robin model.
`timescale 1ns/1ps
module tb_eth_reg_arbiter;

  logic        clk40m = 1'b0;
  logic        reset  = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_wr = '0;
  logic [1:0]  req_length = '0;
  logic [15:0] req_offset = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_grant;
  logic [1:0]  req_done;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        eng_wr;
  logic        eng_length;
  logic [7:0]  eng_offset;
  logic [15:0] eng_wdata;
  logic        eng_new;
  logic [3:0]  eng_state;
  logic [15:0] eng_rdata;

  eth_reg_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(64)) dut (
    .clk40m(clk40m), .reset(reset),
    .req_valid(req_valid), .req_wr(req_wr), .req_length(req_length),
    .req_offset(req_offset), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .eng_wr(eng_wr), .eng_length(eng_length), .eng_offset(eng_offset),
    .eng_wdata(eng_wdata), .eng_new(eng_new),
    .eng_state(eng_state), .eng_rdata(eng_rdata)
  );

  always #12.5 clk40m = ~clk40m;

  // Engine model: takes a command in Wait when NewCommand is high, walks six
  // states and returns to Wait, loading readData on the way back.
  logic [3:0]  eng_q;
  logic        hang = 1'b0;
  logic        force_en = 1'b0;
  logic [3:0]  force_val = 4'h9;
  logic [15:0] eng_rd_val = '0;
  logic [25:0] seen_cmd = '0;
  int          take_cnt = 0;

  assign eng_state = force_en ? force_val : eng_q;

  always @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      eng_q     <= 4'h9;
      eng_rdata <= '0;
    end else if (eng_q == 4'h9) begin
      if (eng_new && !force_en) begin
        eng_q    <= 4'h0;
        take_cnt <= take_cnt + 1;
        seen_cmd <= {eng_wr, eng_length, eng_offset, eng_wdata};
      end
    end else if (eng_q == 4'h5) begin
      eng_q     <= 4'h9;
      eng_rdata <= eng_rd_val;
    end else if (!(hang && eng_q == 4'h2)) begin
      eng_q <= eng_q + 4'h1;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({req_grant, req_done, rsp_err, busy, eng_new}), 32'd0);
    chk({tag, "_cmd"}, 32'({eng_wr, eng_length, eng_offset, eng_wdata}), 32'd0);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk40m);
    reset = 1'b0;
    req_valid = '0;
    hang = 1'b0;
    force_en = 1'b0;
    repeat (2) @(negedge clk40m);
    reset = 1'b1;
  endtask

  // Drive one request set from the current falling edge, then check grant,
  // command fields, latency, done, read data and error flag.
  task automatic run_txn(input logic [1:0] v, input logic [1:0] wr, input logic [1:0] ln,
                         input logic [15:0] off, input logic [31:0] wd, input logic [15:0] rd,
                         input int eg, input logic [15:0] erd, input int elat,
                         input logic eerr, output int gwait);
    int n;
    int takes0;
    logic gb;
    logic [25:0] exp_cmd;
    gb = eg[0];
    exp_cmd = {gb ? wr[1] : wr[0], gb ? ln[1] : ln[0],
               gb ? off[15:8] : off[7:0], gb ? wd[31:16] : wd[15:0]};
    takes0 = take_cnt;
    req_valid = v; req_wr = wr; req_length = ln;
    req_offset = off; req_wdata = wd; eng_rd_val = rd;
    n = 0;
    do begin @(negedge clk40m); n++; end while (req_grant == '0 && n < 60);
    gwait = n;
    if (req_grant == '0) begin
      nchk++; nerr++;
      $display("FAIL grant_wait: no grant after %0d cycles, required within 60", n);
      req_valid = '0;
      return;
    end
    chk("grant", 32'(req_grant), 32'd1 << eg);
    chk("eng_new_at_grant", 32'(eng_new), 32'd1);
    chk("busy_at_grant", 32'(busy), 32'd1);
    chk("eng_cmd", 32'({eng_wr, eng_length, eng_offset, eng_wdata}), 32'(exp_cmd));
    n = 0;
    do begin @(negedge clk40m); n++; end while (req_done == '0 && n < 100);
    req_valid = '0;
    chk("latency", 32'(n), 32'(elat));
    chk("done", 32'(req_done), 32'd1 << eg);
    chk("rdata", 32'(rsp_rdata), 32'(erd));
    chk("err", 32'(rsp_err), 32'(eerr));
    chk("eng_new_at_done", 32'(eng_new), 32'd0);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("eng_cmd_hold", 32'({eng_wr, eng_length, eng_offset, eng_wdata}), 32'(exp_cmd));
    chk("engine_takes", 32'(take_cnt - takes0), 32'd1);
    chk("engine_cmd_seen", 32'(seen_cmd), 32'(exp_cmd));
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  wr;
    logic [1:0]  len;
    logic [15:0] off;
    logic [31:0] wdata;
    logic [15:0] rd;
    int          exp_g;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl[6];
  int   gw;
  int   cnt;
  int   outstanding;
  int   gq[$];
  int   m_ptr;
  logic [15:0] m_rdata;

  initial begin
    // valid, wr, len, offset{r1,r0}, wdata{r1,r0}, engine rdata, grant, rsp_rdata
    tbl[0] = '{2'b01, 2'b01, 2'b01, 16'h0010, 32'h0000_A5A5, 16'hDEAD, 0, 16'h0000};
    tbl[1] = '{2'b10, 2'b00, 2'b10, 16'h9200, 32'h0000_0000, 16'h8870, 1, 16'h8870};
    tbl[2] = '{2'b11, 2'b00, 2'b11, 16'h3020, 32'h0000_0000, 16'h1234, 0, 16'h1234};
    tbl[3] = '{2'b11, 2'b01, 2'b10, 16'h4140, 32'h1111_2222, 16'hBEEF, 1, 16'hBEEF};
    tbl[4] = '{2'b10, 2'b10, 2'b10, 16'h5500, 32'h5A5A_0000, 16'hDEAD, 1, 16'hBEEF};
    tbl[5] = '{2'b11, 2'b11, 2'b01, 16'h6766, 32'hCAFE_F00D, 16'hDEAD, 0, 16'hBEEF};

    // Reset state, during and after reset.
    @(negedge clk40m);
    check_all_zero("reset_held");
    reset = 1'b1;
    @(negedge clk40m);
    check_all_zero("reset_released");

    // Table: single write, single read, round-robin between both requesters.
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].valid, tbl[i].wr, tbl[i].len, tbl[i].off, tbl[i].wdata, tbl[i].rd,
              tbl[i].exp_g, tbl[i].exp_rdata, 9, 1'b0, gw);
    end

    // Engine not in Wait: request must be held off until it returns.
    force_val = 4'h5;
    force_en  = 1'b1;
    req_valid = 2'b01; req_wr = 2'b01; req_length = 2'b01;
    req_offset = 16'h0077; req_wdata = 32'h0000_3C3C;
    cnt = 0;
    repeat (10) begin
      @(negedge clk40m);
      if (req_grant != '0) cnt++;
    end
    chk("no_grant_engine_busy", 32'(cnt), 32'd0);
    force_en = 1'b0;
    run_txn(2'b01, 2'b01, 2'b01, 16'h0077, 32'h0000_3C3C, 16'hDEAD, 0, 16'hBEEF, 9, 1'b0, gw);
    chk("grant_after_engine_wait", 32'(gw), 32'd1);

    // Hung engine: watchdog ends the read with an error after 64 cycles.
    hang = 1'b1;
    run_txn(2'b01, 2'b00, 2'b01, 16'h0033, 32'h0, 16'h1357, 0, 16'hBEEF, 64, 1'b1, gw);
    hang = 1'b0;

    // Reset in the middle of a read: outputs clear at once, no done, pointer back to 0.
    req_valid = 2'b10; req_wr = 2'b00; req_length = 2'b11;
    req_offset = 16'h4400; req_wdata = '0; eng_rd_val = 16'h7777;
    cnt = 0;
    do begin @(negedge clk40m); cnt++; end while (req_grant == '0 && cnt < 60);
    chk("mid_reset_grant", 32'(req_grant), 32'd2);
    repeat (4) @(negedge clk40m);
    chk("mid_reset_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    req_valid = '0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk40m);
      if (req_done != '0) cnt++;
    end
    chk("no_done_after_reset", 32'(cnt), 32'd0);
    reset = 1'b1;
    run_txn(2'b11, 2'b00, 2'b11, 16'h4645, 32'h0, 16'h4242, 0, 16'h4242, 9, 1'b0, gw);

    // Continuous contention from reset: grants alternate, each done before the next grant.
    apply_reset();
    req_valid = 2'b11; req_wr = 2'b00; req_length = 2'b00;
    req_offset = 16'h2010; req_wdata = '0; eng_rd_val = 16'h0F0F;
    outstanding = -1;
    repeat (60) begin
      @(negedge clk40m);
      if (req_done != '0) begin
        chk("contention_done", 32'(req_done), (outstanding < 0) ? 32'd0 : (32'd1 << outstanding));
        outstanding = -1;
      end
      if (req_grant != '0) begin
        chk("contention_grant_overlap", 32'(outstanding), 32'hFFFF_FFFF);
        outstanding = req_grant[1] ? 1 : 0;
        gq.push_back(outstanding);
      end
    end
    req_valid = '0;
    if (gq.size() < 4) begin
      nchk++; nerr++;
      $display("FAIL contention_count: got %0d grants, required at least 4", gq.size());
    end else begin
      for (int i = 0; i < 4; i++) chk("contention_order", 32'(gq[i]), 32'(i % 2));
    end

    // Randomized requests against the round-robin model.
    apply_reset();
    m_ptr = 0;
    m_rdata = '0;
    for (int t = 0; t < 30; t++) begin
      logic [1:0]  v, wr, ln;
      logic [15:0] off, rd, erd;
      logic [31:0] wd;
      int eg;
      v   = 2'($urandom_range(1, 3));
      wr  = 2'($urandom);
      ln  = 2'($urandom);
      off = 16'($urandom);
      wd  = $urandom;
      rd  = 16'($urandom);
      eg  = -1;
      for (int i = 0; i < 2; i++) begin
        int k;
        k = (m_ptr + i) % 2;
        if (eg < 0 && v[k]) eg = k;
      end
      erd = (((wr >> eg) & 2'b01) != 2'b00) ? m_rdata : rd;
      run_txn(v, wr, ln, off, wd, rd, eg, erd, 9, 1'b0, gw);
      m_rdata = erd;
      m_ptr   = (eg + 1) % 2;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
